// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the 5-stage MIPS pipeline.
// Resolves load-use hazards, MEM data-bus waits, exceptions and the
// multi-cycle multiply/divide sequence held in EX.
//
// Ports:
//   clk, rst                    rising-edge clock, sync active-high reset
//   id_read_en_1/2, _addr_1/2   ID register read ports
//   ex_is_load, ex_write_reg_*  EX instruction destination info
//   ex_mdu_op, ex_mdu_div       EX holds a mult/div-class instruction
//   mem_req, mem_ack            MEM stage data-bus handshake
//   exc_req, exc_pc             exception taken / handler address
//   stall[4:0]                  hold for PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   flush, flush_pc             clear all stages and redirect the PC
//   mdu_start/busy/done         MDU sequencing status
//
// Optional: define PIPE_PERF_CNT_EN to add perf_stall_cycles and
// perf_flush_count (stall[0] cycles and flush cycles, wrapping 32-bit).

module pipe_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_read_en_1,
    input  logic        id_read_en_2,
    input  logic [4:0]  id_read_addr_1,
    input  logic [4:0]  id_read_addr_2,
    input  logic        ex_is_load,
    input  logic        ex_write_reg_en,
    input  logic [4:0]  ex_write_reg_addr,
    input  logic        ex_mdu_op,
    input  logic        ex_mdu_div,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    output logic [4:0]  stall,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic        mdu_done
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    localparam int unsigned MAXC = (DIV_CYCLES > MUL_CYCLES) ?
                                   DIV_CYCLES : MUL_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;

    logic            hit_1;
    logic            hit_2;
    logic            load_use;
    logic            mem_wait;
    logic            mdu_go;
    logic            mdu_stall;

    assign hit_1    = id_read_en_1 & (id_read_addr_1 == ex_write_reg_addr);
    assign hit_2    = id_read_en_2 & (id_read_addr_2 == ex_write_reg_addr);
    assign load_use = ex_is_load & ex_write_reg_en &
                      (ex_write_reg_addr != 5'd0) & (hit_1 | hit_2);
    assign mem_wait = mem_req & ~mem_ack;
    assign mdu_go   = (state_q == S_IDLE) & ex_mdu_op & ~exc_req;
    assign mdu_stall = mdu_go | (state_q == S_BUSY);

    always_comb begin
        stall    = 5'b00000;
        flush    = 1'b0;
        flush_pc = 32'h0;
        if (rst) begin
            stall = 5'b00000;
        end else if (exc_req) begin
            flush    = 1'b1;
            flush_pc = exc_pc;
        end else if (mem_wait) begin
            stall = 5'b01111;
        end else if (mdu_stall) begin
            stall = 5'b00111;
        end else if (load_use) begin
            stall = 5'b00011;
        end
    end

    assign mdu_start = ~rst & mdu_go;
    assign mdu_busy  = ~rst & (state_q == S_BUSY);
    assign mdu_done  = ~rst & (state_q == S_DONE) & ~exc_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else if (exc_req) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ex_mdu_op) begin
                        state_q <= S_BUSY;
                        cnt_q   <= ex_mdu_div ? CW'(DIV_CYCLES - 1)
                                              : CW'(MUL_CYCLES - 1);
                    end
                end
                S_BUSY: begin
                    // Leave once the count reaches zero; a one-cycle op
                    // loads zero and still spends one cycle here.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                    if (cnt_q <= CW'(1)) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // EX/MEM only captures the result once MEM is free.
                    if (!mem_wait) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            if (stall[0]) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule
